flip_patch_stream: RTL and testbench
====================================

Name: flip_patch_stream

Overview:
- Streaming successor to the flip/patch integration block. It holds a writable per-word fault map (f and p bits) and applies flip or patch correction to M activation lanes per beat.
- Uses valid/ready handshakes on both sides, a wrapping word-address counter, a run-time mode select and saturating event counters.
- Sits between the fault-scan logic, which loads the map, and the downstream activation consumer.

Parameters:
- N_WORDS, 64, number of words covered by the fault map; must be a multiple of M.
- DATA_W, 16, activation width in bits.
- M, 4, lanes (words) per beat.
- FLIP_MASK, all ones (DATA_W bits), XOR mask applied when a lane is flipped.
- CNT_W, 32, width of each event counter.
- ADDR_W, $clog2(N_WORDS), derived word-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- map_we  in  1  fault-map write strobe.
- map_addr  in  ADDR_W  map word address to write.
- map_f  in  1  flip bit to store.
- map_p  in  1  patch bit to store.
- mode  in  2  correction mode: 00 bypass, 01 flip only, 10 patch only, 11 flip and patch.
- clear_addr  in  1  synchronous return of the address counter to word 0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- activation_org  in  M x DATA_W  original activations.
- activation_cache  in  M x DATA_W  patch values.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- activation_final  out  M x DATA_W  corrected activations.
- f_m  out  M x 1  effective flip per lane (after mode gating).
- p_m  out  M x 1  effective patch per lane (after mode gating).
- base_addr  out  ADDR_W  word address of lane 0 of the current output beat.
- frame_done  out  1  high while the current output beat holds the last group (words N_WORDS-M .. N_WORDS-1).
- count_f  out  CNT_W  number of lanes flipped so far.
- count_p  out  CNT_W  number of lanes patched so far.

Behaviour:
- Reset values:
  - Fault map all zeros; address counter 0.
  - out_valid 0, activation_final 0, f_m/p_m 0, base_addr 0, frame_done 0.
  - count_f/count_p 0.
  - in_ready 1.
- Map write: on clk with map_we, map[map_addr] is updated and takes effect from the next cycle. A beat accepted in the same cycle as a write to one of its words uses the old map value. map_addr >= N_WORDS is ignored.
- Handshakes:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
  - Output data is stable while out_valid && !out_ready.
  - Output is registered: latency is 1 cycle from acceptance to out_valid.
  - With out_ready held high, full throughput is 1 beat per cycle.
- Lane i of an accepted beat maps to word addr+i.
- Effective flags: ef = map_f & mode[0]; ep = map_p & mode[1].
- Lane output selection (patch has priority over flip):
  - ep=1: activation_final = activation_cache.
  - ep=0, ef=1: activation_final = activation_org ^ FLIP_MASK.
  - otherwise: activation_final = activation_org.
- f_m/p_m report ef/ep. A lane with both bits set reports f_m=1 and p_m=1.
- Address counter:
  - Advances by M on each accept.
  - Wraps to 0 when addr+M == N_WORDS; frame_done is set for that beat.
  - clear_addr forces the counter to 0 and takes priority over the advance when coincident with an accept. The beat accepted in that cycle still uses the pre-clear address.
- Counters:
  - On each accept, count_f += popcount(ef & ~ep) and count_p += popcount(ep), evaluated across the M lanes.
  - Each counter saturates at 2^CNT_W-1.
  - Mode changes take effect for beats accepted in the same cycle.
- Output-register reload: when out_valid && out_ready with no new accept, out_valid drops next cycle and all other outputs hold their last values.
- Reset mid-stream: any in-flight beat is discarded. The map is cleared and must be reloaded.

Test Plan:
- Bypass, with N_WORDS=16, M=4:
  - Stimulus: map[5] f=1, mode=00; send beat 1 with all org=16'h1234.
  - Response: out_valid 1 cycle later; all lanes 16'h1234; f_m all 0; base_addr=4; count_f=0.
- Flip vs patch priority:
  - Stimulus: map[4] f=1, map[6] f=1 p=1, mode=11, org=16'h00F0, cache=16'hABCD.
  - Response: lane0=16'hFF0F, lane2=16'hABCD, lanes 1 and 3 = 16'h00F0; count_f=1, count_p=1.
- Wrap and frame_done:
  - Stimulus: stream 5 consecutive beats.
  - Response: base_addr sequence 0,4,8,12,0; frame_done high only on the 4th output.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Response: in_ready=0 after the first beat; output holds; no beat lost or duplicated; counters counted once per beat.
- Write/accept collision:
  - Stimulus: write map[0] p=1 in the same cycle beat 0 is accepted.
  - Response: that beat is unpatched; the next pass over word 0 is patched.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges with out_valid=1.
  - Response: out_valid=0 and counters=0 immediately; after release the first accepted beat has base_addr=0.

Source files
------------

// File: rtl/flip_patch_stream_if.sv
// flip_patch_stream_if: input/output beat handshakes and per-beat results of flip_patch_stream.
interface flip_patch_stream_if #(
    parameter int DATA_W = 16,
    parameter int M = 4,
    parameter int ADDR_W = 6
);
    logic in_valid;
    logic in_ready;
    logic [M-1:0][DATA_W-1:0] activation_org;
    logic [M-1:0][DATA_W-1:0] activation_cache;
    logic out_valid;
    logic out_ready;
    logic [M-1:0][DATA_W-1:0] activation_final;
    logic [M-1:0] f_m;
    logic [M-1:0] p_m;
    logic [ADDR_W-1:0] base_addr;
    logic frame_done;
    modport master (
        output in_valid, activation_org, activation_cache, out_ready,
        input in_ready, out_valid, activation_final, f_m, p_m, base_addr, frame_done
    );
    modport slave (
        input in_valid, activation_org, activation_cache, out_ready,
        output in_ready, out_valid, activation_final, f_m, p_m, base_addr, frame_done
    );
endinterface

// File: rtl/flip_patch_stream.sv
// flip_patch_stream: per-word fault map applying flip/patch correction to M lanes per streamed beat.
module flip_patch_stream #(
    parameter int N_WORDS = 64,
    parameter int DATA_W = 16,
    parameter int M = 4,
    parameter logic [DATA_W-1:0] FLIP_MASK = '1,
    parameter int CNT_W = 32,
    parameter int ADDR_W = $clog2(N_WORDS)
) (
    input  logic clk,
    input  logic reset,
    input  logic map_we_i,
    input  logic [ADDR_W-1:0] map_addr_i,
    input  logic map_f_i,
    input  logic map_p_i,
    input  logic [1:0] mode_i,
    input  logic clear_addr_i,
    flip_patch_stream_if.slave s,
    output logic [CNT_W-1:0] count_f_o,
    output logic [CNT_W-1:0] count_p_o
);
    localparam int PC_W = $clog2(M + 1);
    logic [N_WORDS-1:0] map_f_q, map_p_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0] addr_next;
    logic accept, last_grp;
    logic [M-1:0] ef, ep;
    logic [M-1:0][DATA_W-1:0] fin_d, fin_q;
    logic [M-1:0] f_q, p_q;
    logic [ADDR_W-1:0] base_q;
    logic frame_q, out_valid_q;
    logic [PC_W-1:0] nf, np;
    logic [CNT_W:0] sum_f, sum_p;
    logic [CNT_W-1:0] cnt_f_q, cnt_p_q, cnt_f_d, cnt_p_d;
    assign s.in_ready = !out_valid_q || s.out_ready;
    assign accept = s.in_valid && s.in_ready;
    assign addr_next = {1'b0, addr_q} + (ADDR_W+1)'(M);
    assign last_grp = addr_next == (ADDR_W+1)'(N_WORDS);
    // clear wins over the advance; the beat accepted alongside it still used addr_q
    assign addr_d = clear_addr_i ? '0 : !accept ? addr_q : last_grp ? '0 : addr_next[ADDR_W-1:0];
    always_comb begin
        ef = '0;
        ep = '0;
        fin_d = '0;
        nf = '0;
        np = '0;
        for (int i = 0; i < M; i++) begin
            ef[i] = map_f_q[addr_q + ADDR_W'(i)] & mode_i[0];
            ep[i] = map_p_q[addr_q + ADDR_W'(i)] & mode_i[1];
            fin_d[i] = ep[i] ? s.activation_cache[i] : ef[i] ? s.activation_org[i] ^ FLIP_MASK : s.activation_org[i];
            nf = nf + PC_W'(ef[i] & ~ep[i]);
            np = np + PC_W'(ep[i]);
        end
    end
    assign sum_f = {1'b0, cnt_f_q} + (CNT_W+1)'(nf);
    assign sum_p = {1'b0, cnt_p_q} + (CNT_W+1)'(np);
    assign cnt_f_d = sum_f[CNT_W] ? '1 : sum_f[CNT_W-1:0];
    assign cnt_p_d = sum_p[CNT_W] ? '1 : sum_p[CNT_W-1:0];
    // the map is read combinationally from the registered copy, so a same-cycle write is seen one beat later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_f_q <= '0;
            map_p_q <= '0;
            addr_q <= '0;
        end else begin
            if (map_we_i && ({1'b0, map_addr_i} < (ADDR_W+1)'(N_WORDS))) begin
                map_f_q[map_addr_i] <= map_f_i;
                map_p_q[map_addr_i] <= map_p_i;
            end
            addr_q <= addr_d;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            fin_q <= '0;
            f_q <= '0;
            p_q <= '0;
            base_q <= '0;
            frame_q <= 1'b0;
            cnt_f_q <= '0;
            cnt_p_q <= '0;
        end else begin
            if (s.in_ready)
                out_valid_q <= accept;
            if (accept) begin
                fin_q <= fin_d;
                f_q <= ef;
                p_q <= ep;
                base_q <= addr_q;
                frame_q <= last_grp;
                cnt_f_q <= cnt_f_d;
                cnt_p_q <= cnt_p_d;
            end
        end
    end
    assign s.out_valid = out_valid_q;
    assign s.activation_final = fin_q;
    assign s.f_m = f_q;
    assign s.p_m = p_q;
    assign s.base_addr = base_q;
    assign s.frame_done = frame_q;
    assign count_f_o = cnt_f_q;
    assign count_p_o = cnt_p_q;
endmodule

// File: tb/tb_flip_patch_stream.sv
// tb_flip_patch_stream: directed vector table plus hand-written backpressure, collision, clear and reset sequences.
module tb_flip_patch_stream;
    localparam int NW = 16;
    localparam int DW = 16;
    localparam int M = 4;
    localparam int AW = 4;
    typedef logic [M-1:0][DW-1:0] beat_t;
    typedef struct {
        logic [1:0] mode;
        logic [DW-1:0] org;
        logic [DW-1:0] cache;
        beat_t fin;
        logic [M-1:0] f;
        logic [M-1:0] p;
        logic [AW-1:0] base;
        logic frame;
        int cf;
        int cp;
    } vec_t;
    logic clk = 0, reset = 1, map_we = 0, map_f = 0, map_p = 0, clear_addr = 0;
    logic [AW-1:0] map_addr = '0;
    logic [1:0] mode = '0;
    logic [31:0] count_f, count_p;
    logic [1:0] sat_f, sat_p;
    int n_vec = 0, n_err = 0;
    vec_t tbl [10];
    flip_patch_stream_if #(.DATA_W(DW), .M(M), .ADDR_W(AW)) ifm ();
    flip_patch_stream_if #(.DATA_W(DW), .M(M), .ADDR_W(AW)) ifs ();
    assign ifs.in_valid = ifm.in_valid;
    assign ifs.activation_org = ifm.activation_org;
    assign ifs.activation_cache = ifm.activation_cache;
    assign ifs.out_ready = ifm.out_ready;
    flip_patch_stream #(.N_WORDS(NW), .DATA_W(DW), .M(M), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .map_we_i(map_we), .map_addr_i(map_addr), .map_f_i(map_f),
        .map_p_i(map_p), .mode_i(mode), .clear_addr_i(clear_addr), .s(ifm.slave),
        .count_f_o(count_f), .count_p_o(count_p)
    );
    flip_patch_stream #(.N_WORDS(NW), .DATA_W(DW), .M(M), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .map_we_i(map_we), .map_addr_i(map_addr), .map_f_i(map_f),
        .map_p_i(map_p), .mode_i(mode), .clear_addr_i(clear_addr), .s(ifs.slave),
        .count_f_o(sat_f), .count_p_o(sat_p)
    );
    always #5 clk = ~clk;
    function automatic beat_t rep(input logic [DW-1:0] v);
        beat_t b;
        for (int i = 0; i < M; i++) b[i] = v;
        return b;
    endfunction
    function automatic beat_t lanes(input logic [DW-1:0] l0, l1, l2, l3);
        beat_t b;
        b[0] = l0; b[1] = l1; b[2] = l2; b[3] = l3;
        return b;
    endfunction
    function automatic logic [63:0] sat3(input int v);
        return 64'(v > 3 ? 3 : v);
    endfunction
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic write_map(input logic [AW-1:0] a, input logic f, input logic p);
        map_we = 1; map_addr = a; map_f = f; map_p = p;
        step;
        map_we = 0;
    endtask
    task automatic drive(input logic [1:0] md, input logic [DW-1:0] org, input logic [DW-1:0] cache);
        ifm.in_valid = 1;
        mode = md;
        ifm.activation_org = rep(org);
        ifm.activation_cache = rep(cache);
    endtask
    task automatic chk_out(input string t, input beat_t fin, input logic [M-1:0] f, input logic [M-1:0] p,
                           input logic [AW-1:0] base, input logic frame, input int cf, input int cp);
        chk({t, ".out_valid"}, 64'(ifm.out_valid), 64'(1));
        chk({t, ".final"}, 64'(ifm.activation_final), 64'(fin));
        chk({t, ".f_m"}, 64'(ifm.f_m), 64'(f));
        chk({t, ".p_m"}, 64'(ifm.p_m), 64'(p));
        chk({t, ".base_addr"}, 64'(ifm.base_addr), 64'(base));
        chk({t, ".frame_done"}, 64'(ifm.frame_done), 64'(frame));
        chk({t, ".count_f"}, 64'(count_f), 64'(cf));
        chk({t, ".count_p"}, 64'(count_p), 64'(cp));
        chk({t, ".sat_f"}, 64'(sat_f), sat3(cf));
        chk({t, ".sat_p"}, 64'(sat_p), sat3(cp));
    endtask
    initial begin
        tbl[0] = '{2'b00, 16'h1234, 16'h0000, rep(16'h1234), 4'b0000, 4'b0000, 4'd0, 1'b0, 0, 0};
        tbl[1] = '{2'b00, 16'h1234, 16'h0000, rep(16'h1234), 4'b0000, 4'b0000, 4'd4, 1'b0, 0, 0};
        tbl[2] = '{2'b11, 16'h00F0, 16'hABCD, lanes(16'h00F0, 16'hFF0F, 16'h00F0, 16'h00F0), 4'b0010, 4'b0000, 4'd8, 1'b0, 1, 0};
        tbl[3] = '{2'b11, 16'h00F0, 16'hABCD, lanes(16'h00F0, 16'hABCD, 16'h00F0, 16'h00F0), 4'b0000, 4'b0010, 4'd12, 1'b1, 1, 1};
        tbl[4] = '{2'b11, 16'h0F0F, 16'hABCD, rep(16'h0F0F), 4'b0000, 4'b0000, 4'd0, 1'b0, 1, 1};
        tbl[5] = '{2'b11, 16'h00F0, 16'hABCD, lanes(16'hFF0F, 16'hFF0F, 16'hABCD, 16'h00F0), 4'b0111, 4'b0100, 4'd4, 1'b0, 3, 2};
        tbl[6] = '{2'b01, 16'h00F0, 16'hABCD, lanes(16'h00F0, 16'hFF0F, 16'h00F0, 16'h00F0), 4'b0010, 4'b0000, 4'd8, 1'b0, 4, 2};
        tbl[7] = '{2'b10, 16'h00F0, 16'hABCD, lanes(16'h00F0, 16'hABCD, 16'h00F0, 16'h00F0), 4'b0000, 4'b0010, 4'd12, 1'b1, 4, 3};
        tbl[8] = '{2'b01, 16'h5A5A, 16'hABCD, rep(16'h5A5A), 4'b0000, 4'b0000, 4'd0, 1'b0, 4, 3};
        tbl[9] = '{2'b10, 16'h00F0, 16'hABCD, lanes(16'h00F0, 16'h00F0, 16'hABCD, 16'h00F0), 4'b0000, 4'b0100, 4'd4, 1'b0, 4, 4};
        ifm.in_valid = 0;
        ifm.out_ready = 1;
        ifm.activation_org = '0;
        ifm.activation_cache = '0;
        #2;
        chk("reset.out_valid", 64'(ifm.out_valid), 64'(0));
        chk("reset.in_ready", 64'(ifm.in_ready), 64'(1));
        chk("reset.final", 64'(ifm.activation_final), 64'(0));
        chk("reset.base_addr", 64'(ifm.base_addr), 64'(0));
        chk("reset.count_f", 64'(count_f), 64'(0));
        step;
        step;
        reset = 0;
        write_map(4'd4, 1, 0);
        write_map(4'd5, 1, 0);
        write_map(4'd6, 1, 1);
        write_map(4'd9, 1, 0);
        write_map(4'd13, 0, 1);
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].mode, tbl[k].org, tbl[k].cache);
            step;
            chk($sformatf("v%0d.in_ready", k), 64'(ifm.in_ready), 64'(1));
            chk_out($sformatf("v%0d", k), tbl[k].fin, tbl[k].f, tbl[k].p, tbl[k].base, tbl[k].frame, tbl[k].cf, tbl[k].cp);
        end
        ifm.in_valid = 0;
        step;
        chk("drain.out_valid", 64'(ifm.out_valid), 64'(0));
        chk("drain.final_held", 64'(ifm.activation_final), 64'(tbl[9].fin));
        chk("drain.base_held", 64'(ifm.base_addr), 64'(4));
        ifm.out_ready = 0;
        drive(2'b11, 16'h1111, 16'h2222);
        step;
        chk("bp.in_ready", 64'(ifm.in_ready), 64'(0));
        chk_out("bp.a", lanes(16'h1111, 16'hEEEE, 16'h1111, 16'h1111), 4'b0010, 4'b0000, 4'd8, 1'b0, 5, 4);
        ifm.activation_org = rep(16'h3333);
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("bp.hold%0d.in_ready", k), 64'(ifm.in_ready), 64'(0));
            chk_out($sformatf("bp.hold%0d", k), lanes(16'h1111, 16'hEEEE, 16'h1111, 16'h1111), 4'b0010, 4'b0000, 4'd8, 1'b0, 5, 4);
        end
        ifm.out_ready = 1;
        step;
        chk_out("bp.b", lanes(16'h3333, 16'h2222, 16'h3333, 16'h3333), 4'b0000, 4'b0010, 4'd12, 1'b1, 5, 5);
        ifm.in_valid = 0;
        step;
        chk("bp.drain.out_valid", 64'(ifm.out_valid), 64'(0));
        chk("bp.drain.count_f", 64'(count_f), 64'(5));
        chk("bp.drain.count_p", 64'(count_p), 64'(5));
        drive(2'b11, 16'h5555, 16'h6666);
        map_we = 1; map_addr = 4'd0; map_f = 0; map_p = 1;
        step;
        map_we = 0;
        chk_out("coll.c", rep(16'h5555), 4'b0000, 4'b0000, 4'd0, 1'b0, 5, 5);
        clear_addr = 1;
        step;
        clear_addr = 0;
        chk_out("clr.d", lanes(16'hAAAA, 16'hAAAA, 16'h6666, 16'h5555), 4'b0111, 4'b0100, 4'd4, 1'b0, 7, 6);
        step;
        ifm.in_valid = 0;
        chk_out("coll.e", lanes(16'h6666, 16'h5555, 16'h5555, 16'h5555), 4'b0000, 4'b0001, 4'd0, 1'b0, 7, 7);
        #2;
        reset = 1;
        #1;
        chk("arst.out_valid", 64'(ifm.out_valid), 64'(0));
        chk("arst.count_f", 64'(count_f), 64'(0));
        chk("arst.count_p", 64'(count_p), 64'(0));
        chk("arst.sat_p", 64'(sat_p), 64'(0));
        chk("arst.final", 64'(ifm.activation_final), 64'(0));
        #1;
        reset = 0;
        drive(2'b11, 16'h7777, 16'h8888);
        step;
        ifm.in_valid = 0;
        chk_out("arst.first", rep(16'h7777), 4'b0000, 4'b0000, 4'd0, 1'b0, 0, 0);
        step;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
